// File: rtl/fpnew_pkg.sv
// fpnew_pkg: floating-point format enumeration and bit-width helper
package fpnew_pkg;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  function automatic int unsigned fp_width(fp_format_e f);
    return f == FP64 ? 64 : f == FP32 ? 32 : f == FP8 ? 8 : 16;
  endfunction
endpackage

// File: rtl/redmule_pkg.sv
// redmule_pkg: shared RedMulE types (z collector FSM state)
package redmule_pkg;
  typedef enum logic {Z_FILL, Z_DRAIN} z_coll_state_e;
endpackage

// File: rtl/redmule_z_collector.sv
// redmule_z_collector: buffers up to Depth engine result vectors per tile and drains them via valid/ready
//   clk_i, rst_ni (sync active-low), clear_i (soft clear)
//   capture_i/z_i/last_i : result vectors from the engine, last_i closes the tile
//   z_valid_o/z_ready_i/z_data_o/z_last_o : drain stream, element 0 in LSBs
//   count_o/full_o : occupancy, overflow_o : sticky dropped-capture flag
module redmule_z_collector
  import fpnew_pkg::*;
  import redmule_pkg::*;
#(
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned Width    = 8,
  parameter int unsigned Depth    = 4,
  localparam int unsigned BITW    = fp_width(FpFormat),
  localparam int unsigned CNTW    = $clog2(Depth + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        capture_i,
  input  logic [Width-1:0][BITW-1:0]  z_i,
  input  logic                        last_i,
  output logic                        z_valid_o,
  input  logic                        z_ready_i,
  output logic [Width-1:0][BITW-1:0]  z_data_o,
  output logic                        z_last_o,
  output logic [CNTW-1:0]             count_o,
  output logic                        full_o,
  output logic                        overflow_o
);
  localparam int unsigned PTRW = $clog2(Depth);
  z_coll_state_e state_q, state_d;
  logic [Width-1:0][BITW-1:0] mem_q [Depth];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNTW-1:0] count_q;
  logic overflow_q, drain, fill_we, pop, flush;
  assign drain      = state_q == Z_DRAIN;
  assign fill_we    = !drain && capture_i;
  assign pop        = drain && z_ready_i;
  assign flush      = !rst_ni || clear_i;
  assign wr_ptr_nxt = wr_ptr_q == PTRW'(Depth - 1) ? '0 : wr_ptr_q + PTRW'(1);
  assign rd_ptr_nxt = rd_ptr_q == PTRW'(Depth - 1) ? '0 : rd_ptr_q + PTRW'(1);
  assign z_valid_o  = drain;
  assign z_data_o   = drain ? mem_q[rd_ptr_q] : '0;
  assign z_last_o   = drain && count_q == CNTW'(1);
  assign count_o    = count_q;
  assign full_o     = count_q == CNTW'(Depth);
  assign overflow_o = overflow_q;
  always_comb begin
    state_d = state_q;
    state_d = fill_we && (last_i || count_q == CNTW'(Depth - 1)) ? Z_DRAIN :
              pop && z_last_o ? Z_FILL : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q    <= Z_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_we) begin
        wr_ptr_q <= wr_ptr_nxt;
        count_q  <= count_q + CNTW'(1);
      end
      if (pop) begin
        wr_ptr_q <= z_last_o ? '0 : wr_ptr_q;
        rd_ptr_q <= z_last_o ? '0 : rd_ptr_nxt;
        count_q  <= count_q - CNTW'(1);
      end
      if (drain && capture_i) overflow_q <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!flush && fill_we) mem_q[wr_ptr_q] <= z_i;
  end
endmodule

// File: tb/tb_redmule_z_collector.sv
// tb_redmule_z_collector: directed stimulus with a queue-based reference model checked every cycle
module tb_redmule_z_collector;
  localparam int W = 8;
  localparam int D = 4;
  localparam int B = 16;
  typedef logic [W-1:0][B-1:0] vec_t;
  logic clk = 0, rst_n = 0, clear = 0, capture = 0, last = 0, ready = 0;
  vec_t z = '0, data;
  logic valid, zlast, full, ovf;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  vec_t q[$];
  bit m_drain = 0, m_ovf = 0;

  always #5 clk = ~clk;

  redmule_z_collector #(.FpFormat(fpnew_pkg::FP16), .Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .capture_i(capture), .z_i(z), .last_i(last),
    .z_valid_o(valid), .z_ready_i(ready), .z_data_o(data), .z_last_o(zlast),
    .count_o(count), .full_o(full), .overflow_o(ovf)
  );

  function automatic vec_t vec(input logic [15:0] b, input int step);
    vec_t v;
    for (int k = 0; k < W; k++) v[k] = b + 16'(k * step);
    return v;
  endfunction

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n || clear) begin
      q.delete();
      m_drain = 0;
      m_ovf = 0;
    end else if (!m_drain) begin
      if (capture) begin
        q.push_back(z);
        if (last || q.size() == D) m_drain = 1;
      end
    end else begin
      if (capture) m_ovf = 1;
      if (ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_drain = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", valid, m_drain);
      check("model_data", data, m_drain ? q[0] : vec_t'(0));
      check("model_last", zlast, m_drain && q.size() == 1);
      check("model_count", count, q.size());
      check("model_full", full, q.size() == D);
      check("model_overflow", ovf, m_ovf);
    end
  end

  task automatic cap(input vec_t v, input bit l);
    @(posedge clk); #1;
    capture = 1; z = v; last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      capture = 0; last = 0;
    end
  endtask

  initial begin
    vec_t hold;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; chk_en = 1;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    for (int i = 0; i < 4; i++) cap(vec(16'h3C00 + 16'(i * 'h200), 0), 0);
    ready = 1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("fill4_full", full, 1);
      check("fill4_data", data, vec(16'h3C00 + 16'(i * 'h200), 0));
      check("fill4_last", zlast, i == 3);
    end
    @(negedge clk);
    check("fill4_done_valid", valid, 0);
    check("fill4_done_count", count, 0);
    ready = 0;
    cap(vec(16'h1000, 1), 0);
    cap(vec(16'h2000, 1), 1);
    idle(1);
    ready = 1;
    @(negedge clk);
    check("two_b0_data", data, vec(16'h1000, 1));
    check("two_b0_last", zlast, 0);
    @(negedge clk);
    check("two_b1_data", data, vec(16'h2000, 1));
    check("two_b1_last", zlast, 1);
    @(negedge clk);
    check("two_done_valid", valid, 0);
    ready = 0;
    cap(vec(16'h5000, 3), 1);
    idle(1);
    hold = vec(16'h5000, 3);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", valid, 1);
      check("stall_data", data, hold);
    end
    ready = 1;
    @(negedge clk);
    check("stall_done_valid", valid, 0);
    ready = 0;
    cap(vec(16'h6000, 1), 0);
    cap(vec(16'h7000, 1), 1);
    cap(vec(16'h9999, 1), 0);
    idle(1);
    @(negedge clk);
    check("ovf_set", ovf, 1);
    check("ovf_data", data, vec(16'h6000, 1));
    check("ovf_count", count, 2);
    ready = 1;
    @(negedge clk);
    check("ovf_b1_data", data, vec(16'h7000, 1));
    check("ovf_b1_last", zlast, 1);
    @(negedge clk);
    check("ovf_drained_valid", valid, 0);
    ready = 0;
    idle(2);
    @(negedge clk);
    check("ovf_sticky", ovf, 1);
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    @(negedge clk);
    check("ovf_cleared", ovf, 0);
    for (int i = 0; i < 4; i++) cap(vec(16'hA000 + 16'(i * 'h100), 1), 0);
    idle(1);
    ready = 1;
    @(negedge clk);
    check("rst_b0", data, vec(16'hA000, 1));
    @(negedge clk);
    check("rst_b1", data, vec(16'hA100, 1));
    @(posedge clk); #1 rst_n = 0; ready = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midrst_valid", valid, 0);
    check("midrst_count", count, 0);
    check("midrst_data", data, 0);
    check("midrst_last", zlast, 0);
    check("midrst_full", full, 0);
    cap(vec(16'hB000, 2), 1);
    idle(1);
    @(negedge clk);
    check("refill_data", data, vec(16'hB000, 2));
    check("refill_last", zlast, 1);
    ready = 1;
    @(negedge clk);
    check("refill_done", valid, 0);
    ready = 0;
    @(posedge clk); #1 clear = 1; capture = 1; z = vec(16'hC000, 1); last = 1;
    @(posedge clk); #1 clear = 0; capture = 0; last = 0;
    @(negedge clk);
    check("clrcap_count", count, 0);
    check("clrcap_valid", valid, 0);
    cap(vec(16'hD000, 1), 1);
    idle(1);
    @(negedge clk);
    check("clrcap_next_count", count, 1);
    check("clrcap_next_data", data, vec(16'hD000, 1));
    ready = 1;
    @(negedge clk);
    check("clrcap_next_done", valid, 0);
    ready = 0;
    idle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
